// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_tx_frame transmitter
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    localparam int MIN_DIV = 2;
    function automatic parity_e decode_parity(input logic [1:0] mode);
        return (mode == 2'd1) ? PAR_EVEN : (mode == 2'd2) ? PAR_ODD : PAR_NONE;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous circular FIFO with level; push ignored when full, pop ignored when empty
module uart_tx_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [LVL_W-1:0] r_level;
    logic w_push, w_pop;
    assign full = r_level == LVL_W'(DEPTH);
    assign empty = r_level == '0;
    assign w_push = push && !full;
    assign w_pop = pop && !empty;
    assign dout = r_mem[r_rd];
    assign level = r_level;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 5-9 bit UART TX with valid/ready input, parity, 1/2 stop bits; UART_TX_FIFO_EN selects FIFO over holding register
module uart_tx_frame import uart_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DIV_W = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic [DATA_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int BIT_W = $clog2(DATA_W);
    logic [DATA_W-1:0] w_head;
    logic w_empty, w_full, w_push, w_load;
    assign s_ready = !w_full;
    assign w_push = s_valid && s_ready;
`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(w_push), .din(s_data), .pop(w_load),
        .dout(w_head), .full(w_full), .empty(w_empty), .level(fifo_level)
    );
`else
    logic [DATA_W-1:0] r_hold;
    logic r_hold_valid;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_hold <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_push) begin
            r_hold <= s_data;
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    assign w_head = r_hold;
    assign w_empty = !r_hold_valid;
    assign w_full = r_hold_valid;
    assign fifo_level = LVL_W'(r_hold_valid);
`endif
    tx_state_e r_state, w_state;
    parity_e r_pmode, w_pmode;
    logic [DIV_W-1:0] r_cnt, w_cnt, r_div, w_div;
    logic [BIT_W-1:0] r_bit, w_bit;
    logic [DATA_W-1:0] r_shift, w_shift;
    logic r_par, w_par, r_stop2, w_stop2, r_stop_n, w_stop_n, r_tx, w_tx, w_last;
    assign w_last = r_cnt == r_div - 1'b1;
    always_comb begin
        w_state = r_state;
        w_pmode = r_pmode;
        w_cnt = w_last ? '0 : r_cnt + 1'b1;
        w_div = r_div;
        w_bit = r_bit;
        w_shift = r_shift;
        w_par = r_par;
        w_stop2 = r_stop2;
        w_stop_n = r_stop_n;
        w_tx = r_tx;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                w_load = !w_empty;
            end
            START: if (w_last) begin
                w_state = DATA;
                w_bit = '0;
                w_tx = r_shift[0];
            end
            DATA: if (w_last) begin
                if (r_bit == BIT_W'(DATA_W - 1)) begin
                    w_state = (r_pmode == PAR_NONE) ? STOP : PARITY;
                    w_tx = (r_pmode == PAR_NONE) ? 1'b1 : r_par ^ (r_pmode == PAR_ODD);
                    w_stop_n = 1'b0;
                end else begin
                    w_bit = r_bit + 1'b1;
                    w_shift = r_shift >> 1;
                    w_tx = r_shift[1];
                end
            end
            PARITY: if (w_last) begin
                w_state = STOP;
                w_tx = 1'b1;
                w_stop_n = 1'b0;
            end
            STOP: if (w_last) begin
                if (r_stop2 && !r_stop_n) begin
                    w_stop_n = 1'b1;
                end else begin
                    w_state = IDLE;
                    w_tx = 1'b1;
                    w_load = !w_empty;
                end
            end
            default: begin
                w_state = IDLE;
                w_tx = 1'b1;
            end
        endcase
        // Frame start from IDLE or straight out of the last stop bit; config is frozen here
        if (w_load) begin
            w_state = START;
            w_tx = 1'b0;
            w_cnt = '0;
            w_shift = w_head;
            w_par = ^w_head;
            w_div = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
            w_pmode = decode_parity(cfg_parity);
            w_stop2 = cfg_stop2;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_pmode <= PAR_NONE;
            r_cnt <= '0;
            r_div <= DIV_W'(MIN_DIV);
            r_bit <= '0;
            r_shift <= '0;
            r_par <= 1'b0;
            r_stop2 <= 1'b0;
            r_stop_n <= 1'b0;
            r_tx <= 1'b1;
        end else begin
            r_state <= w_state;
            r_pmode <= w_pmode;
            r_cnt <= w_cnt;
            r_div <= w_div;
            r_bit <= w_bit;
            r_shift <= w_shift;
            r_par <= w_par;
            r_stop2 <= w_stop2;
            r_stop_n <= w_stop_n;
            r_tx <= w_tx;
        end
    assign tx = r_tx;
    assign busy = r_state != IDLE;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized scoreboard bench; a monitor decodes every frame against a bit-list reference model
module tb_uart_tx_frame;
    localparam int DATA_W = 8;
    localparam int DIV_W = 16;
    localparam int LVL_W = 5;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DIV_W-1:0] cfg_div = 16'd4;
    logic [1:0] cfg_parity = 2'd0;
    logic cfg_stop2 = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_ready, tx, busy;
    logic [LVL_W-1:0] fifo_level;

    uart_tx_frame dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int last_hs = 0;
    int last_fall = 0;
    logic prev_busy = 1'b0;
    int snap_div;
    logic [1:0] snap_par;
    logic snap_st2;
    logic [DATA_W-1:0] exp_q[$];
    int starts[$];
    int lvls[$];
    logic line_q[$];

    always @(posedge clk) begin
        cyc++;
        snap_div = int'(cfg_div);
        snap_par = cfg_parity;
        snap_st2 = cfg_stop2;
    end

    always @(negedge clk) begin
        if (prev_busy && !busy) last_fall = cyc;
        prev_busy = busy;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: frame = start(0), data LSB first, optional parity, 1 or 2 stop(1); each bit held max(div,2) clocks
    task automatic run_frame();
        logic [DATA_W-1:0] d;
        logic b[$];
        int dv;
        logic ok;
        int bad_k;
        logic bad_tx, bad_busy;
        dv = (snap_div < 2) ? 2 : snap_div;
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got a start bit at cycle %0d expected no frame", cyc);
            d = '0;
        end else d = exp_q.pop_front();
        b.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) b.push_back(d[i]);
        if (snap_par == 2'd1) b.push_back(^d);
        else if (snap_par == 2'd2) b.push_back(~^d);
        b.push_back(1'b1);
        if (snap_st2) b.push_back(1'b1);
        ok = 1'b1;
        bad_k = 0;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        for (int k = 0; k < b.size() * dv; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) return;
            if (k == 2) lvls.push_back(int'(fifo_level));
            line_q.push_back(tx);
            if (ok && (tx !== b[k / dv] || busy !== 1'b1)) begin
                ok = 1'b0;
                bad_k = k;
                bad_tx = tx;
                bad_busy = busy;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL frame data=%h div=%0d par=%0d stop2=%0d: cycle %0d got tx=%b busy=%b expected tx=%b busy=1",
                     d, dv, snap_par, snap_st2, bad_k, bad_tx, bad_busy, b[bad_k / dv]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) exp_q.delete();
            else if (tx == 1'b0) run_frame();
        end
    end

    task automatic send(input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        s_data = d;
        s_valid = 1'b1;
        while (!s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected acceptance", t);
            s_valid = 1'b0;
            return;
        end
        exp_q.push_back(d);
        last_hs = cyc + 1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic set_cfg(input int dv, input int par, input int st2);
        @(negedge clk);
        cfg_div = DIV_W'(dv);
        cfg_parity = 2'(par);
        cfg_stop2 = 1'(st2);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 20000);
        @(negedge clk);
        if (t >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: got busy=%b pending=%0d expected idle with nothing pending", busy, exp_q.size());
        end
    endtask

    task automatic wait_starts(input int n);
        int t;
        t = 0;
        while (starts.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (starts.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_start: got %0d frames expected %0d", starts.size(), n);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_ready", s_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_cfg(4, 0, 0);
        starts.delete();
        line_q.delete();
        send(8'hA5);
        wait_idle();
        chk("t1_frames", starts.size(), 1);
        if (starts.size() == 1) begin
            chk("t1_latency", starts[0] - last_hs, 1);
            chk("t1_length", last_fall - starts[0], 40);
        end
        if (line_q.size() == 40) begin
            chk("t1_bit0", line_q[4], 1);
            chk("t1_bit1", line_q[8], 0);
            chk("t1_stop", line_q[39], 1);
        end

        set_cfg(3, 1, 1);
        starts.delete();
        line_q.delete();
        send(8'h07);
        wait_idle();
        if (starts.size() == 1) chk("t2_length", last_fall - starts[0], 36);
        chk("t2_samples", line_q.size(), 36);
        if (line_q.size() == 36) begin
            chk("t2_parity", line_q[28], 1);
            chk("t2_stop_first", line_q[30], 1);
            chk("t2_stop_last", line_q[35], 1);
        end

        set_cfg(2, 0, 0);
        starts.delete();
        lvls.delete();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        wait_idle();
        chk("t3_frames", starts.size(), 3);
        if (starts.size() == 3 && lvls.size() == 3) begin
            chk("t3_gap0", starts[1] - starts[0], 20);
            chk("t3_gap1", starts[2] - starts[1], 20);
            chk("t3_busy_span", last_fall - starts[0], 60);
            chk("t3_level0", lvls[0], (DEPTH < 2) ? DEPTH : 2);
            chk("t3_level1", lvls[1], 1);
            chk("t3_level2", lvls[2], 0);
        end

        set_cfg(8, 0, 0);
        starts.delete();
        send(8'h40);
        for (int i = 0; i < DEPTH; i++) send(8'(8'h41 + i));
        @(negedge clk);
        chk("t4_ready_full", s_ready, 0);
        chk("t4_level_full", fifo_level, DEPTH);
        s_data = 8'hEE;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("t4_level_after_drop", fifo_level, DEPTH);
        wait_idle();
        chk("t4_frames", starts.size(), DEPTH + 1);

        set_cfg(0, 0, 0);
        starts.delete();
        send(8'h5A);
        wait_idle();
        if (starts.size() == 1) chk("t5_div0_length", last_fall - starts[0], 20);
        set_cfg(4, 0, 0);
        starts.delete();
        send(8'h11);
        send(8'h22);
        wait_starts(1);
        repeat (5) @(negedge clk);
        cfg_div = 16'd8;
        wait_idle();
        chk("t5_frames", starts.size(), 2);
        if (starts.size() == 2) begin
            chk("t5_first_length", starts[1] - starts[0], 40);
            chk("t5_second_length", last_fall - starts[1], 80);
        end

        set_cfg(4, 0, 0);
        starts.delete();
        send(8'h3C);
        send(8'h55);
        wait_starts(1);
        if (starts.size() > 0) begin
            s0 = starts[0];
            while (cyc < s0 + 17) @(negedge clk);
            chk("t6_level_before", fifo_level, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("t6_reset_tx", tx, 1);
            chk("t6_reset_busy", busy, 0);
            chk("t6_reset_level", fifo_level, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            repeat (2) @(negedge clk);
            chk("t6_idle_after", busy, 0);
            starts.delete();
            send(8'h81);
            wait_idle();
            chk("t6_frames_after", starts.size(), 1);
        end

        for (int it = 0; it < 25; it++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 15)) @(negedge clk);
                cfg_div = DIV_W'($urandom_range(0, 6));
                cfg_parity = 2'($urandom_range(0, 3));
                cfg_stop2 = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) wait_idle();
            else repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        chk("final_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
